imem_refill_responder: RTL and testbench

Main-memory responder on the instruction-cache refill interface. The fetch stage's cache raises a line request on a miss. This block accepts the request and waits a fixed access latency. It then streams the whole line back one word per cycle from an internal word-addressed memory. It sits between the fetch stage's cache and the instruction backing store. It also provides a host write port used to load programs.

---
 rtl/imem_refill_responder_if.sv | 32 +++
 rtl/imem_refill_responder.sv | 124 ++++++++++++
 tb/tb_imem_refill_responder.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/imem_refill_responder_if.sv
// rtl/imem_refill_responder_if.sv - refill request/response and host write bundle
interface imem_refill_responder_if #(
    parameter int LINE_WORDS = 4,
    parameter int DEPTH      = 256,
    parameter int ADDR_W     = 32
);
    localparam int IDX_W = $clog2(LINE_WORDS);
    localparam int AW    = $clog2(DEPTH);

    logic              req_valid;
    logic [ADDR_W-1:0] req_addr;
    logic              req_ready;

    logic              resp_valid;
    logic [31:0]       resp_data;
    logic [IDX_W-1:0]  resp_idx;
    logic              resp_last;

    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [31:0]       wr_data;

    modport master (
        output req_valid, req_addr, wr_en, wr_addr, wr_data,
        input  req_ready, resp_valid, resp_data, resp_idx, resp_last
    );

    modport slave (
        input  req_valid, req_addr, wr_en, wr_addr, wr_data,
        output req_ready, resp_valid, resp_data, resp_idx, resp_last
    );
endinterface

// File: rtl/imem_refill_responder.sv
// rtl/imem_refill_responder.sv - fixed-latency instruction line refill responder
module imem_refill_responder #(
    parameter int LINE_WORDS = 4,
    parameter int LATENCY    = 3,
    parameter int DEPTH      = 256,
    parameter int ADDR_W     = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    imem_refill_responder_if.slave  bus
);
    localparam int IDX_W = $clog2(LINE_WORDS);
    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        BURST = 2'd2
    } state_t;

    state_t           stateQ, stateD;
    logic [CNT_W-1:0] cntQ, cntD;
    logic [IDX_W-1:0] idxQ, idxD;
    logic [AW-1:0]    baseQ, baseD;

    logic [31:0]      mem [DEPTH];

    logic             reqReadyQ;
    logic             respValidQ;
    logic [31:0]      respDataQ;
    logic [IDX_W-1:0] respIdxQ;
    logic             respLastQ;

    logic [AW-1:0]    lineWord;
    logic [AW-1:0]    reqBase;
    logic [AW-1:0]    readAddr;
    logic [31:0]      respDataD;
    logic             unusedAddr;

    // Byte address -> word address -> aligned line base; high bits wrap away.
    assign lineWord   = bus.req_addr[AW+1:2];
    assign reqBase    = lineWord & ~AW'(LINE_WORDS - 1);
    assign unusedAddr = ^bus.req_addr;

    always_comb begin
        stateD = stateQ;
        cntD   = cntQ;
        idxD   = idxQ;
        baseD  = baseQ;
        case (stateQ)
            IDLE: begin
                if (bus.req_valid) begin
                    baseD = reqBase;
                    idxD  = '0;
                    cntD  = CNT_W'(LATENCY - 1);
                    stateD = (LATENCY == 1) ? BURST : WAIT;
                end
            end
            WAIT: begin
                cntD = cntQ - CNT_W'(1);
                if (cntD == '0) begin
                    stateD = BURST;
                    idxD   = '0;
                end
            end
            BURST: begin
                if (idxQ == IDX_W'(LINE_WORDS - 1)) begin
                    stateD = IDLE;
                    idxD   = '0;
                end else begin
                    idxD = idxQ + IDX_W'(1);
                end
            end
            default: begin
                stateD = IDLE;
                cntD   = '0;
                idxD   = '0;
            end
        endcase
    end

    // Outputs are computed from the next state so they appear registered in
    // the cycle they belong to; the memory read sees pre-write contents.
    assign readAddr  = baseD + AW'(idxD);
    assign respDataD = (stateD == BURST) ? mem[readAddr] : 32'd0;

    always_ff @(posedge clk) begin
        if (reset) begin
            stateQ     <= IDLE;
            cntQ       <= '0;
            idxQ       <= '0;
            baseQ      <= '0;
            reqReadyQ  <= 1'b1;
            respValidQ <= 1'b0;
            respDataQ  <= 32'd0;
            respIdxQ   <= '0;
            respLastQ  <= 1'b0;
        end else begin
            stateQ     <= stateD;
            cntQ       <= cntD;
            idxQ       <= idxD;
            baseQ      <= baseD;
            reqReadyQ  <= (stateD == IDLE);
            respValidQ <= (stateD == BURST);
            respDataQ  <= respDataD;
            respIdxQ   <= (stateD == BURST) ? idxD : '0;
            respLastQ  <= (stateD == BURST) && (idxD == IDX_W'(LINE_WORDS - 1));
        end
    end

    // Backing store is not reset so a loaded program survives a core reset.
    always_ff @(posedge clk) begin
        if (bus.wr_en) begin
            mem[bus.wr_addr] <= bus.wr_data;
        end
    end

    assign bus.req_ready  = reqReadyQ;
    assign bus.resp_valid = respValidQ;
    assign bus.resp_data  = respDataQ;
    assign bus.resp_idx   = respIdxQ;
    assign bus.resp_last  = respLastQ;
endmodule

// File: tb/tb_imem_refill_responder.sv
// tb/tb_imem_refill_responder.sv - directed scoreboard bench for imem_refill_responder
module tb_imem_refill_responder;
    localparam int LW    = 4;
    localparam int LAT   = 3;
    localparam int DEPTH = 256;

    logic clk;
    logic reset;

    imem_refill_responder_if #(.LINE_WORDS(LW), .DEPTH(DEPTH), .ADDR_W(32)) bus ();

    imem_refill_responder #(
        .LINE_WORDS(LW), .LATENCY(LAT), .DEPTH(DEPTH), .ADDR_W(32)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [31:0] model [DEPTH];
    logic [31:0] expQ [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic hostWrite(input int a, input logic [31:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = a[7:0];
        bus.wr_data = d;
        tick();
        bus.wr_en   = 1'b0;
        model[a]    = d;
    endtask

    task automatic checkResetValues(input string tag);
        chk({tag, "_ready"}, {31'd0, bus.req_ready}, 32'd1);
        chk({tag, "_valid"}, {31'd0, bus.resp_valid}, 32'd0);
        chk({tag, "_data"}, bus.resp_data, 32'd0);
        chk({tag, "_idx"}, {30'd0, bus.resp_idx}, 32'd0);
        chk({tag, "_last"}, {31'd0, bus.resp_last}, 32'd0);
    endtask

    // Starts in a cycle where the block is expected idle; ends in cycle LAT+LW
    // after acceptance without advancing past it.
    task automatic refill(input logic [31:0] addr, input logic hold, input logic [31:0] nextAddr,
                          input int wrCyc, input int wrA, input logic [31:0] wrD, input int abortCyc);
        int base;
        logic inBurst;
        logic [31:0] exp;
        base = ((addr >> 2) & ~(LW - 1)) % DEPTH;
        for (int k = 0; k < LW; k++) expQ.push_back(model[(base + k) % DEPTH]);
        bus.req_valid = 1'b1;
        bus.req_addr  = addr;
        chk("ready_before_req", {31'd0, bus.req_ready}, 32'd1);
        tick();
        bus.req_valid = hold;
        bus.req_addr  = nextAddr;
        for (int cyc = 1; cyc <= LAT + LW; cyc++) begin
            inBurst = (cyc >= LAT) && (cyc < LAT + LW);
            chk($sformatf("ready_c%0d", cyc), {31'd0, bus.req_ready}, {31'd0, cyc == LAT + LW});
            chk($sformatf("valid_c%0d", cyc), {31'd0, bus.resp_valid}, {31'd0, inBurst});
            if (inBurst) begin
                if (expQ.size() > 0) exp = expQ.pop_front();
                else exp = 32'hDEAD_BEEF;
                chk($sformatf("data_c%0d", cyc), bus.resp_data, exp);
                chk($sformatf("idx_c%0d", cyc), {30'd0, bus.resp_idx}, cyc - LAT);
                chk($sformatf("last_c%0d", cyc), {31'd0, bus.resp_last},
                    {31'd0, cyc == LAT + LW - 1});
            end else begin
                chk($sformatf("idle_data_c%0d", cyc), bus.resp_data, 32'd0);
                chk($sformatf("idle_last_c%0d", cyc), {31'd0, bus.resp_last}, 32'd0);
            end
            if (cyc == LAT + LW) break;
            if (cyc == wrCyc) begin
                bus.wr_en   = 1'b1;
                bus.wr_addr = wrA[7:0];
                bus.wr_data = wrD;
                model[wrA]  = wrD;
            end
            if (cyc == abortCyc) reset = 1'b1;
            tick();
            bus.wr_en = 1'b0;
            if (cyc == abortCyc) begin
                checkResetValues("abort");
                reset = 1'b0;
                expQ.delete();
                return;
            end
        end
        chk("scoreboard_empty", expQ.size(), 32'd0);
    endtask

    initial begin
        reset         = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h14;
        bus.wr_en     = 1'b0;
        bus.wr_addr   = '0;
        bus.wr_data   = '0;
        for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;

        // Reset held two cycles with a pending request.
        tick();
        checkResetValues("rst1");
        tick();
        checkResetValues("rst2");
        reset         = 1'b0;
        bus.req_valid = 1'b0;
        tick();
        checkResetValues("post_rst");

        // Preload lines used below.
        for (int i = 0; i < 4; i++) hostWrite(4 + i, 32'hA0 + i);
        for (int i = 0; i < 4; i++) hostWrite(8 + i, 32'hB0 + i);
        for (int i = 0; i < 4; i++) hostWrite(252 + i, 32'hC0 + i);
        for (int i = 0; i < 4; i++) hostWrite(i, 32'hD0 + i);
        checkResetValues("post_load");

        // Single refill; write mem[5] on the edge that emits idx 1 (edge LAT+1).
        refill(32'h14, 1'b0, 32'h0, LAT, 5, 32'hFF, 0);

        // Back-to-back with request held through the busy window.
        refill(32'h14, 1'b1, 32'h20, 0, 0, 32'h0, 0);
        refill(32'h20, 1'b0, 32'h0, 0, 0, 32'h0, 0);

        // Wrap: top line of memory, then an address one line past the end.
        refill(32'h3F0, 1'b0, 32'h0, 0, 0, 32'h0, 0);
        refill(32'h400, 1'b0, 32'h0, 0, 0, 32'h0, 0);

        // Restore the line, abort mid-burst, then refill it cleanly.
        hostWrite(5, 32'hA1);
        refill(32'h14, 1'b0, 32'h0, 0, 0, 32'h0, 4);
        refill(32'h14, 1'b0, 32'h0, 0, 0, 32'h0, 0);

        tick();
        tick();
        chk("final_valid", {31'd0, bus.resp_valid}, 32'd0);
        chk("final_ready", {31'd0, bus.req_ready}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
